// File: rtl/input_conditioner_bank.sv
// N-channel input conditioner: synchroniser, glitch filter and registered edge pulses.
// Define INPUTCOND_STICKY_EN to add per-channel sticky edge flags (event_pending/event_clr).
module input_conditioner_bank #(
  parameter int   N           = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   DEBOUNCE    = 4,
  parameter logic INIT        = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] sig_in,
  output logic [N-1:0] cond,
  output logic [N-1:0] rising,
  output logic [N-1:0] falling,
  output logic         any_edge,
  output logic [N-1:0] event_pending,
  input  logic [N-1:0] event_clr
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [N-1:0]  sync_q [SYNC_STAGES];
  logic [N-1:0]  sync_d [SYNC_STAGES];
  logic [N-1:0]  cond_q, cond_d;
  logic [N-1:0]  rising_q, rising_d;
  logic [N-1:0]  falling_q, falling_d;
  logic [CW-1:0] cnt_q [N];
  logic [CW-1:0] cnt_d [N];
  logic [N-1:0]  s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = sig_in;
    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // The counter only advances while s differs from cond; any agreement restarts it.
  always_comb begin
    cond_d    = cond_q;
    rising_d  = '0;
    falling_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s[i] != cond_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          cond_d[i]    = s[i];
          rising_d[i]  = s[i];
          falling_d[i] = ~s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= {N{INIT}};
      end
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
      cond_q    <= {N{INIT}};
      rising_q  <= '0;
      falling_q <= '0;
    end else begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_d[k];
      end
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      cond_q    <= cond_d;
      rising_q  <= rising_d;
      falling_q <= falling_d;
    end
  end

  assign cond     = cond_q;
  assign rising   = rising_q;
  assign falling  = falling_q;
  assign any_edge = |(rising_q | falling_q);

`ifdef INPUTCOND_STICKY_EN
  logic [N-1:0] pending_q, pending_d;

  // Set is taken from the pulse next-state so it lands on the same edge as the pulse and beats a clear.
  always_comb begin
    pending_d = (pending_q & ~event_clr) | rising_d | falling_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign event_pending = pending_q;
`else
  logic unused_event_clr;
  assign unused_event_clr = ^event_clr;
  assign event_pending    = '0;
`endif

endmodule

// File: tb/tb_input_conditioner_bank.sv
// Directed self-checking bench for input_conditioner_bank (N=4, SYNC_STAGES=2, DEBOUNCE=4, INIT=0).
module tb_input_conditioner_bank;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] sig_in;
  logic [3:0] cond, rising, falling, event_pending, event_clr;
  logic       any_edge;

  int checks = 0;
  int errors = 0;

  input_conditioner_bank #(
    .N(4),
    .SYNC_STAGES(2),
    .DEBOUNCE(4),
    .INIT(1'b0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .sig_in(sig_in),
    .cond(cond),
    .rising(rising),
    .falling(falling),
    .any_edge(any_edge),
    .event_pending(event_pending),
    .event_clr(event_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One active edge, then settle on the falling edge where inputs change and outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs n edges after a sig_in change; pulses expected only on edge 6.
  task automatic run_edges(input int n, input logic [3:0] exp_rise, input logic [3:0] exp_fall,
                           input logic [3:0] cond_before, input logic [3:0] cond_after);
    for (int e = 1; e <= n; e++) begin
      step();
      check($sformatf("rising e%0d", e), 32'(rising), 32'((e == 6) ? exp_rise : 4'b0000));
      check($sformatf("falling e%0d", e), 32'(falling), 32'((e == 6) ? exp_fall : 4'b0000));
      check($sformatf("any_edge e%0d", e), 32'(any_edge),
            32'((e == 6) && ((exp_rise | exp_fall) != 4'b0000)));
      check($sformatf("cond e%0d", e), 32'(cond), 32'((e >= 6) ? cond_after : cond_before));
`ifndef INPUTCOND_STICKY_EN
      check($sformatf("pending e%0d", e), 32'(event_pending), 32'(4'b0000));
`endif
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    sig_in    = 4'b1111;
    event_clr = 4'b0000;
    @(negedge clk);

    // Reset held 3 cycles with inputs high
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset cond", 32'(cond), 32'(4'b0000));
      check("reset rising", 32'(rising), 32'(4'b0000));
      check("reset any_edge", 32'(any_edge), 32'(1'b0));
      check("reset pending", 32'(event_pending), 32'(4'b0000));
    end
    reset_n = 1'b1;
    run_edges(8, 4'b1111, 4'b0000, 4'b0000, 4'b1111);

    // Return all channels low
    sig_in = 4'b0000;
    event_clr = 4'b1111;
    run_edges(8, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
    event_clr = 4'b0000;

    // Three-cycle glitch on channel 0 must be rejected
    sig_in = 4'b0001;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (e == 3) sig_in = 4'b0000;
      check($sformatf("glitch cond e%0d", e), 32'(cond), 32'(4'b0000));
      check($sformatf("glitch edges e%0d", e), 32'({rising, falling}), 32'(8'h00));
      check($sformatf("glitch any_edge e%0d", e), 32'(any_edge), 32'(1'b0));
    end

    // Clean toggle on channel 2
    sig_in = 4'b0100;
    run_edges(20, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    sig_in = 4'b0000;
    run_edges(10, 4'b0000, 4'b0100, 4'b0100, 4'b0000);

    // Two channels rising together
    sig_in = 4'b0101;
    run_edges(8, 4'b0101, 4'b0000, 4'b0000, 4'b0101);
    sig_in = 4'b0000;
    run_edges(8, 4'b0000, 4'b0101, 4'b0101, 4'b0000);

    // Reset pulse at edge 4 of a pending rise on channel 1
    sig_in = 4'b0010;
    for (int e = 1; e <= 3; e++) begin
      step();
      check($sformatf("midcount rising e%0d", e), 32'(rising), 32'(4'b0000));
    end
    reset_n = 1'b0;
    step();
    check("midcount reset cond", 32'(cond), 32'(4'b0000));
    check("midcount reset rising", 32'(rising), 32'(4'b0000));
    reset_n = 1'b1;
    run_edges(8, 4'b0010, 4'b0000, 4'b0000, 4'b0010);

`ifdef INPUTCOND_STICKY_EN
    // Sticky flags: start clean
    sig_in  = 4'b0000;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("sticky after reset", 32'(event_pending), 32'(4'b0000));
    for (int i = 0; i < 4; i++) step();
    sig_in = 4'b1000;
    for (int e = 1; e <= 8; e++) begin
      step();
      check($sformatf("sticky set e%0d", e), 32'(event_pending), 32'((e >= 6) ? 4'b1000 : 4'b0000));
    end
    event_clr = 4'b1000;
    step();
    event_clr = 4'b0000;
    check("sticky clear", 32'(event_pending), 32'(4'b0000));
    sig_in = 4'b0000;
    for (int e = 1; e <= 5; e++) step();
    event_clr = 4'b1000;
    step();
    event_clr = 4'b0000;
    check("sticky falling pulse", 32'(falling), 32'(4'b1000));
    check("sticky set wins", 32'(event_pending), 32'(4'b1000));
    step();
    check("sticky holds", 32'(event_pending), 32'(4'b1000));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
